// File: rtl/abus_pkg.sv
// Shared ABUS definitions: id encoding, timeout counter width and master-port FSM states.
package abus_pkg;

    localparam int unsigned ABUS_ID_WIDTH = 3;
    localparam logic [ABUS_ID_WIDTH-1:0] ABUS_ID_NONE = 3'b000;
    localparam int unsigned ABUS_TO_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } abus_state_e;

endpackage

// File: rtl/abus_req_fifo.sv
// Synchronous request FIFO holding {address, wdata}; head is always visible on pop_data.
module abus_req_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                      (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/abus_master_port.sv
// Master-side ABUS adapter: buffers local requests, holds each on the bus until granted
// or timed out, and returns a single-cycle response pulse.
module abus_master_port
    import abus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MASTER_ID  = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                     bus_clk,
    input  logic                     bus_rstb,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_WIDTH-1:0]    req_address,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_error,
    output logic                     bus_mvalid,
    output logic [ABUS_ID_WIDTH-1:0] bus_mid,
    output logic [ADDR_WIDTH-1:0]    bus_maddress,
    output logic [DATA_WIDTH-1:0]    bus_mwdata,
    input  logic [ABUS_ID_WIDTH-1:0] bus_mbid,
    input  logic [DATA_WIDTH-1:0]    bus_mrdata
);

    localparam int unsigned ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [ABUS_ID_WIDTH-1:0] OWN_ID  = ABUS_ID_WIDTH'(MASTER_ID);
    localparam logic [ABUS_TO_WIDTH-1:0] TO_LAST = ABUS_TO_WIDTH'(TIMEOUT - 1);

    abus_state_e              state;
    logic [ABUS_TO_WIDTH-1:0] to_cnt;
    logic [ENTRY_WIDTH-1:0]   head;
    logic [ADDR_WIDTH-1:0]    head_address;
    logic [DATA_WIDTH-1:0]    head_wdata;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     grant;
    logic                     expire;
    logic                     pop;

    assign head_address = head[ENTRY_WIDTH-1:DATA_WIDTH];
    assign head_wdata   = head[DATA_WIDTH-1:0];

    // A grant in the expiry cycle takes priority over the timeout.
    assign grant     = (state == ST_REQ) && (bus_mbid == OWN_ID);
    assign expire    = (state == ST_REQ) && !grant && (to_cnt == TO_LAST);
    assign pop       = grant || expire;
    assign req_ready = !fifo_full;

    abus_req_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (bus_clk),
        .rst_n     (bus_rstb),
        .push      (req_valid),
        .push_data ({req_address, req_wdata}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge bus_clk or negedge bus_rstb) begin
        if (!bus_rstb) begin
            state        <= ST_IDLE;
            to_cnt       <= '0;
            rsp_valid    <= 1'b0;
            rsp_error    <= 1'b0;
            rsp_rdata    <= '0;
            bus_mvalid   <= 1'b0;
            bus_mid      <= ABUS_ID_NONE;
            bus_maddress <= '0;
            bus_mwdata   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state        <= ST_REQ;
                        to_cnt       <= '0;
                        bus_mvalid   <= 1'b1;
                        bus_mid      <= OWN_ID;
                        bus_maddress <= head_address;
                        bus_mwdata   <= head_wdata;
                    end
                end
                ST_REQ: begin
                    if (grant || expire) begin
                        state        <= grant ? ST_DATA : ST_IDLE;
                        bus_mvalid   <= 1'b0;
                        bus_mid      <= ABUS_ID_NONE;
                        bus_maddress <= '0;
                        bus_mwdata   <= '0;
                        rsp_valid    <= expire;
                        rsp_error    <= expire;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= bus_mrdata;
                    // The granted entry was popped on the grant edge, so the head here is the next one.
                    if (!fifo_empty) begin
                        state        <= ST_REQ;
                        to_cnt       <= '0;
                        bus_mvalid   <= 1'b1;
                        bus_mid      <= OWN_ID;
                        bus_maddress <= head_address;
                        bus_mwdata   <= head_wdata;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_abus_master_port.sv
// Directed bench for abus_master_port with MASTER_ID=1, FIFO_DEPTH=4, TIMEOUT=15.
module tb_abus_master_port;

    logic        bus_clk = 1'b0;
    logic        bus_rstb;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_address;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_error;
    logic        bus_mvalid;
    logic [2:0]  bus_mid;
    logic [15:0] bus_maddress;
    logic [15:0] bus_mwdata;
    logic [2:0]  bus_mbid;
    logic [15:0] bus_mrdata;

    int total = 0;
    int bad   = 0;

    abus_master_port #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .MASTER_ID  (1),
        .FIFO_DEPTH (4),
        .TIMEOUT    (15)
    ) dut (
        .bus_clk      (bus_clk),
        .bus_rstb     (bus_rstb),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_address  (req_address),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .bus_mvalid   (bus_mvalid),
        .bus_mid      (bus_mid),
        .bus_maddress (bus_maddress),
        .bus_mwdata   (bus_mwdata),
        .bus_mbid     (bus_mbid),
        .bus_mrdata   (bus_mrdata)
    );

    always #5 bus_clk = ~bus_clk;

    // Advance to the next falling edge, dropping req_valid once it has been accepted.
    task automatic step();
        logic acc;
        acc = req_valid && req_ready;
        @(negedge bus_clk);
        if (acc) req_valid = 1'b0;
    endtask

    task automatic push_one(input logic [15:0] a, input logic [15:0] d);
        req_valid   = 1'b1;
        req_address = a;
        req_wdata   = d;
        step();
    endtask

    task automatic wait_mvalid(input int max_cyc);
        int n;
        n = 0;
        while (!bus_mvalid && n < max_cyc) begin
            step();
            n++;
        end
        total++;
        if (bus_mvalid !== 1'b1) begin
            bad++;
            $display("FAIL wait_mvalid: mvalid=%b required 1 within %0d cycles", bus_mvalid, max_cyc);
        end
    endtask

    task automatic test_reset();
        bus_rstb = 1'b0;
        @(negedge bus_clk);
        total++;
        if ({req_ready, rsp_valid, rsp_error, bus_mvalid} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_flags: got %b required 1000", {req_ready, rsp_valid, rsp_error, bus_mvalid});
        end
        total++;
        if ({bus_mid, bus_maddress, bus_mwdata, rsp_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_fields: mid=%h addr=%h wdata=%h rdata=%h required 0",
                     bus_mid, bus_maddress, bus_mwdata, rsp_rdata);
        end
        bus_rstb = 1'b1;
        step();
    endtask

    task automatic test_single();
        int n;
        push_one(16'h1234, 16'hBEEF);
        total++;
        if (bus_mvalid !== 1'b0 || bus_mid !== 3'd0) begin
            bad++;
            $display("FAIL single_latency1: mvalid=%b mid=%0d required 0 0", bus_mvalid, bus_mid);
        end
        step();
        total++;
        if (bus_mvalid !== 1'b1 || bus_mid !== 3'd1 || bus_maddress !== 16'h1234 || bus_mwdata !== 16'hBEEF) begin
            bad++;
            $display("FAIL single_req: mvalid=%b mid=%0d addr=%h wdata=%h required 1 1 1234 beef",
                     bus_mvalid, bus_mid, bus_maddress, bus_mwdata);
        end
        n = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus_mvalid === 1'b1 && bus_mid === 3'd1 && bus_maddress === 16'h1234) n++;
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL single_hold: stable cycles=%0d required 3", n);
        end
        bus_mbid = 3'd1;
        step();
        bus_mbid   = 3'd0;
        bus_mrdata = 16'h5A5A;
        total++;
        if (bus_mvalid !== 1'b0 || bus_mid !== 3'd0 || bus_maddress !== 16'h0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_data: mvalid=%b mid=%0d addr=%h rsp_valid=%b required 0 0 0 0",
                     bus_mvalid, bus_mid, bus_maddress, rsp_valid);
        end
        step();
        bus_mrdata = 16'h0;
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h5A5A || rsp_error !== 1'b0) begin
            bad++;
            $display("FAIL single_rsp: valid=%b rdata=%h error=%b required 1 5a5a 0", rsp_valid, rsp_rdata, rsp_error);
        end
        step();
        total++;
        if (rsp_valid !== 1'b0 || bus_mvalid !== 1'b0) begin
            bad++;
            $display("FAIL single_pulse: rsp_valid=%b mvalid=%b required 0 0", rsp_valid, bus_mvalid);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs [5];
        logic [15:0] wdats [5];
        logic [15:0] rdats [5];
        addrs = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004};
        wdats = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004};
        rdats = '{16'hD000, 16'hD011, 16'hD022, 16'hD033, 16'hD044};
        for (int i = 0; i < 4; i++) begin
            req_valid   = 1'b1;
            req_address = addrs[i];
            req_wdata   = wdats[i];
            total++;
            if (req_ready !== 1'b1) begin
                bad++;
                $display("FAIL fill_ready%0d: req_ready=%b required 1", i, req_ready);
            end
            @(negedge bus_clk);
        end
        req_valid   = 1'b1;
        req_address = addrs[4];
        req_wdata   = wdats[4];
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_full: req_ready=%b required 0", req_ready);
        end
        step();
        step();
        total++;
        if (req_ready !== 1'b0 || req_valid !== 1'b1) begin
            bad++;
            $display("FAIL fill_held: req_ready=%b req_valid=%b required 0 1", req_ready, req_valid);
        end
        for (int k = 0; k < 5; k++) begin
            wait_mvalid(10);
            total++;
            if (bus_maddress !== addrs[k] || bus_mwdata !== wdats[k]) begin
                bad++;
                $display("FAIL b2b_order%0d: addr=%h wdata=%h required %h %h",
                         k, bus_maddress, bus_mwdata, addrs[k], wdats[k]);
            end
            bus_mbid = 3'd1;
            step();
            bus_mbid   = 3'd0;
            bus_mrdata = rdats[k];
            step();
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== rdats[k] || rsp_error !== 1'b0) begin
                bad++;
                $display("FAIL b2b_rsp%0d: valid=%b rdata=%h error=%b required 1 %h 0",
                         k, rsp_valid, rsp_rdata, rsp_error, rdats[k]);
            end
        end
        step();
        total++;
        if (bus_mvalid !== 1'b0 || req_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_drain: mvalid=%b req_valid=%b req_ready=%b required 0 0 1",
                     bus_mvalid, req_valid, req_ready);
        end
    endtask

    task automatic test_timeout();
        int n;
        push_one(16'h0A0A, 16'h1111);
        push_one(16'h0B0B, 16'h2222);
        wait_mvalid(10);
        total++;
        if (bus_maddress !== 16'h0A0A) begin
            bad++;
            $display("FAIL to_head: addr=%h required 0a0a", bus_maddress);
        end
        n = 0;
        while (bus_mvalid && n < 40) begin
            n++;
            step();
        end
        total++;
        if (n != 15) begin
            bad++;
            $display("FAIL to_cycles: req cycles=%0d required 15", n);
        end
        total++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 16'h0) begin
            bad++;
            $display("FAIL to_rsp: valid=%b error=%b rdata=%h required 1 1 0000", rsp_valid, rsp_error, rsp_rdata);
        end
        step();
        total++;
        if (bus_mvalid !== 1'b1 || bus_maddress !== 16'h0B0B || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL to_next: mvalid=%b addr=%h rsp_valid=%b required 1 0b0b 0",
                     bus_mvalid, bus_maddress, rsp_valid);
        end
        // Grant the second entry in its 15th REQ cycle.
        n = 1;
        while (n < 15) begin
            step();
            n++;
        end
        total++;
        if (bus_mvalid !== 1'b1) begin
            bad++;
            $display("FAIL last_still_req: mvalid=%b required 1", bus_mvalid);
        end
        bus_mbid = 3'd1;
        step();
        bus_mbid   = 3'd0;
        bus_mrdata = 16'hC3C3;
        total++;
        if (rsp_valid !== 1'b0 || bus_mvalid !== 1'b0) begin
            bad++;
            $display("FAIL last_data: rsp_valid=%b mvalid=%b required 0 0", rsp_valid, bus_mvalid);
        end
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 16'hC3C3) begin
            bad++;
            $display("FAIL last_rsp: valid=%b error=%b rdata=%h required 1 0 c3c3", rsp_valid, rsp_error, rsp_rdata);
        end
        step();
    endtask

    task automatic test_other_id();
        int n;
        logic [2:0] ids [7];
        ids = '{3'd3, 3'd0, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
        push_one(16'h0C0C, 16'h3333);
        wait_mvalid(10);
        n = 0;
        while (bus_mvalid && n < 40) begin
            bus_mbid = ids[n % 7];
            n++;
            step();
        end
        bus_mbid = 3'd0;
        total++;
        if (n != 15 || rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin
            bad++;
            $display("FAIL other_id_timeout: cycles=%0d valid=%b error=%b required 15 1 1", n, rsp_valid, rsp_error);
        end
        push_one(16'h0D0D, 16'h4444);
        wait_mvalid(10);
        bus_mbid = 3'd3;
        step();
        step();
        step();
        total++;
        if (bus_mvalid !== 1'b1 || rsp_valid !== 1'b0 || bus_maddress !== 16'h0D0D) begin
            bad++;
            $display("FAIL other_id_ignored: mvalid=%b rsp_valid=%b addr=%h required 1 0 0d0d",
                     bus_mvalid, rsp_valid, bus_maddress);
        end
        bus_mbid = 3'd1;
        step();
        bus_mbid   = 3'd0;
        bus_mrdata = 16'h7E7E;
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 16'h7E7E) begin
            bad++;
            $display("FAIL other_id_rsp: valid=%b error=%b rdata=%h required 1 0 7e7e", rsp_valid, rsp_error, rsp_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int rsp_cnt;
        int mv_cnt;
        push_one(16'h0E00, 16'h5550);
        push_one(16'h0E01, 16'h5551);
        push_one(16'h0E02, 16'h5552);
        wait_mvalid(10);
        bus_mbid = 3'd1;
        step();
        bus_mbid   = 3'd0;
        bus_mrdata = 16'hDEAD;
        #1 bus_rstb = 1'b0;
        #1;
        total++;
        if ({rsp_valid, rsp_error, bus_mvalid, bus_mid, bus_maddress, bus_mwdata, rsp_rdata} !== '0 ||
            req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_data_outputs: rsp_valid=%b mvalid=%b mid=%0d req_ready=%b required 0 0 0 1",
                     rsp_valid, bus_mvalid, bus_mid, req_ready);
        end
        @(negedge bus_clk);
        bus_rstb = 1'b1;
        rsp_cnt  = 0;
        mv_cnt   = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp_valid) rsp_cnt++;
            if (bus_mvalid) mv_cnt++;
        end
        total++;
        if (rsp_cnt != 0 || mv_cnt != 0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_dropped: rsp pulses=%0d mvalid cycles=%0d req_ready=%b required 0 0 1",
                     rsp_cnt, mv_cnt, req_ready);
        end
        // Reset while mvalid is high must clear the bus outputs without a clock edge.
        push_one(16'h0F0F, 16'h6666);
        wait_mvalid(10);
        #1 bus_rstb = 1'b0;
        #1;
        total++;
        if (bus_mvalid !== 1'b0 || bus_mid !== 3'd0 || bus_maddress !== 16'h0 || bus_mwdata !== 16'h0) begin
            bad++;
            $display("FAIL rst_async: mvalid=%b mid=%0d addr=%h wdata=%h required 0 0 0 0",
                     bus_mvalid, bus_mid, bus_maddress, bus_mwdata);
        end
        @(negedge bus_clk);
        bus_rstb = 1'b1;
        step();
        step();
        total++;
        if (bus_mvalid !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_async_after: mvalid=%b rsp_valid=%b required 0 0", bus_mvalid, rsp_valid);
        end
    endtask

    initial begin
        bus_rstb    = 1'b0;
        req_valid   = 1'b0;
        req_address = '0;
        req_wdata   = '0;
        bus_mbid    = '0;
        bus_mrdata  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_other_id();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
